// File: rtl/gardner_ted_loop.sv
// Gardner timing-error detector on a 2-samples/symbol stream, with optional PI loop filter.
// Optional feature macro: GARDNER_LOOP_FILTER_EN (PI filter driving ctrl_valid/ctrl_out).
module gardner_ted_loop #(
  parameter int ERR_SHIFT = 15,
  parameter int KP_SHIFT  = 2,
  parameter int KI_SHIFT  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [15:0] in_data,
  input  logic               sync_clr,
  output logic               sym_valid,
  output logic signed [15:0] sym_out,
  output logic               err_valid,
  output logic signed [15:0] err_out,
  output logic               ctrl_valid,
  output logic signed [15:0] ctrl_out
);

  function automatic logic signed [15:0] sat16_33(input logic signed [32:0] x);
    if (x > 33'sd32767)       return 16'sh7fff;
    else if (x < -33'sd32768) return 16'sh8000;
    else                      return x[15:0];
  endfunction

  function automatic logic signed [15:0] sat16_18(input logic signed [17:0] x);
    if (x > 18'sd32767)       return 16'sh7fff;
    else if (x < -18'sd32768) return 16'sh8000;
    else                      return x[15:0];
  endfunction

  logic               r_ph;
  logic signed [15:0] r_mid;
  logic signed [15:0] r_prev_sym;
  logic               r_vld_p1;
  logic signed [15:0] r_sym_p1;
  logic signed [15:0] r_err_p1;

  logic signed [16:0] w_diff_p0;
  logic signed [32:0] w_mid_ext_p0;
  logic signed [32:0] w_diff_ext_p0;
  logic signed [32:0] w_prod_p0;
  logic signed [32:0] w_shift_p0;
  logic signed [15:0] w_err_p0;
  logic               w_sym_take_p0;

  // Stage p0: error term for the incoming symbol sample
  assign w_diff_p0     = $signed({r_prev_sym[15], r_prev_sym}) - $signed({in_data[15], in_data});
  assign w_mid_ext_p0  = $signed({{17{r_mid[15]}}, r_mid});
  assign w_diff_ext_p0 = $signed({{16{w_diff_p0[16]}}, w_diff_p0});
  assign w_prod_p0     = w_mid_ext_p0 * w_diff_ext_p0;
  assign w_shift_p0    = w_prod_p0 >>> ERR_SHIFT;
  assign w_err_p0      = sat16_33(w_shift_p0);
  // sync_clr on an accepted sample forces it to be taken as a mid-sample
  assign w_sym_take_p0 = in_valid && r_ph && !sync_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph       <= 1'b0;
      r_mid      <= '0;
      r_prev_sym <= '0;
      r_vld_p1   <= 1'b0;
      r_sym_p1   <= '0;
      r_err_p1   <= '0;
    end else begin
      r_vld_p1 <= 1'b0;
      if (in_valid) begin
        if (w_sym_take_p0) begin
          r_err_p1   <= w_err_p0;
          r_sym_p1   <= in_data;
          r_vld_p1   <= 1'b1;
          r_prev_sym <= in_data;
          r_ph       <= 1'b0;
        end else begin
          r_mid <= in_data;
          r_ph  <= 1'b1;
        end
      end else if (sync_clr) begin
        r_ph <= 1'b0;
      end
    end
  end

  // Stage p1: registered TED outputs
  assign sym_valid = r_vld_p1;
  assign err_valid = r_vld_p1;
  assign sym_out   = r_sym_p1;
  assign err_out   = r_err_p1;

`ifdef GARDNER_LOOP_FILTER_EN
  logic signed [15:0] r_integ;
  logic               r_vld_p2;
  logic signed [15:0] r_ctrl_p2;

  logic signed [17:0] w_err_ext_p1;
  logic signed [17:0] w_integ_sum_p1;
  logic signed [15:0] w_integ_next_p1;
  logic signed [17:0] w_ctrl_sum_p1;

  assign w_err_ext_p1    = $signed({{2{r_err_p1[15]}}, r_err_p1});
  assign w_integ_sum_p1  = $signed({{2{r_integ[15]}}, r_integ}) + (w_err_ext_p1 >>> KI_SHIFT);
  assign w_integ_next_p1 = sat16_18(w_integ_sum_p1);
  // Proportional path adds to the already-updated integrator
  assign w_ctrl_sum_p1   = (w_err_ext_p1 >>> KP_SHIFT)
                         + $signed({{2{w_integ_next_p1[15]}}, w_integ_next_p1});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_integ   <= '0;
      r_vld_p2  <= 1'b0;
      r_ctrl_p2 <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_integ   <= w_integ_next_p1;
        r_ctrl_p2 <= sat16_18(w_ctrl_sum_p1);
      end
    end
  end

  // Stage p2: loop-filter output
  assign ctrl_valid = r_vld_p2;
  assign ctrl_out   = r_ctrl_p2;
`else
  assign ctrl_valid = 1'b0;
  assign ctrl_out   = '0;
`endif

endmodule

// File: tb/tb_gardner_ted_loop.sv
// Randomized + directed bench for gardner_ted_loop against an integer reference model.
module tb_gardner_ted_loop;
  localparam int ERR_SHIFT = 15;
  localparam int KP_SHIFT  = 2;
  localparam int KI_SHIFT  = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               sync_clr;
  logic               sym_valid;
  logic signed [15:0] sym_out;
  logic               err_valid;
  logic signed [15:0] err_out;
  logic               ctrl_valid;
  logic signed [15:0] ctrl_out;

  gardner_ted_loop #(.ERR_SHIFT(ERR_SHIFT), .KP_SHIFT(KP_SHIFT), .KI_SHIFT(KI_SHIFT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .sync_clr(sync_clr),
    .sym_valid(sym_valid), .sym_out(sym_out), .err_valid(err_valid), .err_out(err_out),
    .ctrl_valid(ctrl_valid), .ctrl_out(ctrl_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: symbol phase, held samples, integrator and expected outputs
  int m_ph, m_mid, m_prev, m_integ;
  int e_symv, e_sym, e_errv, e_err, e_ctrlv, e_ctrl;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat16(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  task automatic model_step(input bit r, input bit v, input int d, input bit s);
    longint prod;
    if (r) begin
      m_ph = 0; m_mid = 0; m_prev = 0; m_integ = 0;
      e_symv = 0; e_sym = 0; e_errv = 0; e_err = 0; e_ctrlv = 0; e_ctrl = 0;
      return;
    end
`ifdef GARDNER_LOOP_FILTER_EN
    if (e_errv != 0) begin
      m_integ = sat16(longint'(m_integ) + (longint'(e_err) >>> KI_SHIFT));
      e_ctrl  = sat16((longint'(e_err) >>> KP_SHIFT) + longint'(m_integ));
      e_ctrlv = 1;
    end else begin
      e_ctrlv = 0;
    end
`else
    e_ctrlv = 0;
    e_ctrl  = 0;
`endif
    e_symv = 0;
    e_errv = 0;
    if (v) begin
      if (s || m_ph == 0) begin
        m_mid = d;
        m_ph  = 1;
      end else begin
        prod   = longint'(m_mid) * (longint'(m_prev) - longint'(d));
        e_err  = sat16(prod >>> ERR_SHIFT);
        e_sym  = d;
        e_errv = 1;
        e_symv = 1;
        m_prev = d;
        m_ph   = 0;
      end
    end else if (s) begin
      m_ph = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit v, input int d, input bit s);
    reset    = r;
    in_valid = v;
    in_data  = 16'(d);
    sync_clr = s;
    model_step(r, v, d, s);
    @(posedge clk);
    #1;
    chk("sym_valid", int'(sym_valid), e_symv);
    chk("sym_out", int'(sym_out), e_sym);
    chk("err_valid", int'(err_valid), e_errv);
    chk("err_out", int'(err_out), e_err);
    chk("ctrl_valid", int'(ctrl_valid), e_ctrlv);
    chk("ctrl_out", int'(ctrl_out), e_ctrl);
  endtask

  int d_rand;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; sync_clr = 1'b0;

    for (int i = 0; i < 3; i++) cyc(1'b1, (i % 2) == 0, 1234 + i, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0);

    // First symbol from reset, then two more at -62 each to exercise the loop filter
    cyc(1'b0, 1'b1, 1000, 1'b0);
    cyc(1'b0, 1'b1, 2000, 1'b0);
    chk("first_err_valid", int'(err_valid), 1);
    chk("first_err", int'(err_out), -62);
    chk("first_sym", int'(sym_out), 2000);
    cyc(1'b0, 1'b1, 1000, 1'b0);
`ifdef GARDNER_LOOP_FILTER_EN
    chk("ctrl_1", int'(ctrl_out), -17);
`else
    chk("ctrl_off_1", int'(ctrl_valid), 0);
`endif
    cyc(1'b0, 1'b1, 4000, 1'b0);
    chk("second_err", int'(err_out), -62);
    cyc(1'b0, 1'b1, 1000, 1'b0);
`ifdef GARDNER_LOOP_FILTER_EN
    chk("ctrl_2", int'(ctrl_out), -18);
`else
    chk("ctrl_off_2", int'(ctrl_valid), 0);
`endif
    cyc(1'b0, 1'b1, 6000, 1'b0);
    chk("third_err", int'(err_out), -62);
    cyc(1'b0, 1'b0, 0, 1'b0);
`ifdef GARDNER_LOOP_FILTER_EN
    chk("ctrl_3", int'(ctrl_out), -19);
`else
    chk("ctrl_off_3", int'(ctrl_valid), 0);
`endif

    // Idle gap between mid and symbol samples
    cyc(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b1, 1000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 77, 1'b0);
      chk("gap_no_pulse", int'(err_valid), 0);
    end
    cyc(1'b0, 1'b1, 2000, 1'b0);
    chk("gap_err", int'(err_out), -62);

    // Saturation of the positive error
    cyc(1'b0, 1'b0, 0, 1'b1);
    cyc(1'b0, 1'b1, 555, 1'b0);
    cyc(1'b0, 1'b1, 32767, 1'b0);
    cyc(1'b0, 1'b1, 32767, 1'b0);
    cyc(1'b0, 1'b1, -32768, 1'b0);
    chk("sat_err", int'(err_out), 32767);

    // sync_clr on an accepted sample at ph=1 re-aligns the pair
    cyc(1'b0, 1'b1, 100, 1'b0);
    cyc(1'b0, 1'b1, 200, 1'b1);
    chk("sync_no_err", int'(err_valid), 0);
    cyc(1'b0, 1'b1, 300, 1'b0);
    chk("sync_err_valid", int'(err_valid), 1);
    chk("sync_err", int'(err_out), -202);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) d_rand = int'($urandom_range(0, 4000)) - 2000;
      else                           d_rand = int'($urandom_range(0, 65535)) - 32768;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, d_rand,
          $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
